// File: rtl/fifo_byte_reader.sv
// Read-side consumer of the async FIFO: pairs popped nibbles into bytes (low nibble first)
// and presents them on a valid/ready port through a 2-entry buffer. Optional: FIFO_RD_PARITY_EN.
module fifo_byte_reader #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned DEPTH  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       empty,
   input  logic [3:0] rdata,
   output logic       rinc,
   input  logic       flush,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       partial
`ifdef FIFO_RD_PARITY_EN
   ,output logic      m_parity
`endif
);

   logic [1:0] count;
   logic       head;
   logic       tail;
   logic       inflight;
   logic [3:0] hold;
   logic [7:0] mem [DEPTH];
`ifdef FIFO_RD_PARITY_EN
   logic       par_mem [DEPTH];
`endif
   logic [2:0] credit;
   logic       capture;
   logic       push;
   logic       pop;

   // Credit counts nibbles already owned (buffered, held, in flight); 4 = two full bytes.
   always_comb begin
      credit  = {count, 1'b0} + {2'b00, partial} + {2'b00, inflight};
      rinc    = ~reset & ~empty & (credit < 3'd4);
      capture = (RD_LAT == 0) ? rinc : inflight;
      push    = capture & partial;
      pop     = m_valid & m_ready;
      tail    = head ^ count[0];
   end

   assign m_valid = (count != 2'd0);
   assign m_data  = mem[head];
`ifdef FIFO_RD_PARITY_EN
   assign m_parity = par_mem[head];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= 1'b0;
         partial  <= 1'b0;
         hold     <= '0;
      end else begin
         inflight <= (RD_LAT == 1) && rinc;
         if (push) begin
            partial <= 1'b0;
         end else if (capture && !flush) begin
            partial <= 1'b1;
            hold    <= rdata;
         end else if (flush) begin
            partial <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         head  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
`ifdef FIFO_RD_PARITY_EN
            par_mem[i] <= 1'b0;
`endif
         end
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (pop)
            head <= ~head;
         if (push) begin
            mem[tail] <= {rdata, hold};
`ifdef FIFO_RD_PARITY_EN
            par_mem[tail] <= ~^{rdata, hold};
`endif
         end
      end
   end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Directed bench for fifo_byte_reader: a FIFO model feeds nibbles, expected bytes go to a
// scoreboard queue that a negedge monitor drains on every output transfer.
module tb_fifo_byte_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       empty;
   logic [3:0] rdata;
   logic       rinc;
   logic       flush;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       partial;
`ifdef FIFO_RD_PARITY_EN
   logic       m_parity;
`endif

   typedef struct {
      logic [7:0] data;
      logic       par;
   } exp_t;

   exp_t       exp_q [$];
   logic [3:0] fifo_q [$];
   int         vectors = 0;
   int         miscompares = 0;
   logic       stall = 1'b0;
   logic [7:0] stall_data = '0;

   fifo_byte_reader #(.RD_LAT(1), .DEPTH(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .empty   (empty),
      .rdata   (rdata),
      .rinc    (rinc),
      .flush   (flush),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .partial (partial)
`ifdef FIFO_RD_PARITY_EN
      ,.m_parity(m_parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [3:0] n);
      fifo_q.push_back(n);
      empty = 1'b0;
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic p);
      exp_t e;
      e.data = d;
      e.par  = p;
      exp_q.push_back(e);
   endtask

   // FIFO model with one cycle of read latency
   always @(posedge clk) begin
      if (rinc && fifo_q.size() != 0) begin
         logic [3:0] nib;
         nib = fifo_q.pop_front();
         #1;
         rdata = nib;
         empty = (fifo_q.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         stall = 1'b0;
      end else begin
         if (rinc)
            chk("rinc_while_empty", {31'd0, empty}, 32'd0);
         if (stall) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {24'd0, m_data}, {24'd0, stall_data});
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got %0h expected none", m_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("byte", {24'd0, m_data}, {24'd0, e.data});
`ifdef FIFO_RD_PARITY_EN
               chk("parity", {31'd0, m_parity}, {31'd0, e.par});
               chk("parity_calc", {31'd0, m_parity}, {31'd0, ~^m_data});
`endif
            end
         end
         stall      = m_valid && !m_ready;
         stall_data = m_data;
      end
   end

   initial begin
      int rn;
      int mvn;
      int last_r;
      int first_mv;

      // Reset held with a non-empty FIFO interface
      reset   = 1'b1;
      empty   = 1'b0;
      rdata   = 4'hF;
      flush   = 1'b0;
      m_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("reset_rinc", {31'd0, rinc}, 32'd0);
         chk("reset_valid", {31'd0, m_valid}, 32'd0);
         chk("reset_data", {24'd0, m_data}, 32'd0);
      end
      step();
      empty = 1'b1;
      reset = 1'b0;
      step();

      // Single byte, latency and valid width
      m_ready = 1'b1;
      load(4'h3);
      load(4'hA);
      expect_byte(8'hA3, 1'b1);
      rn = 0; mvn = 0; last_r = -1; first_mv = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rinc) begin
            rn++;
            last_r = i;
         end
         if (m_valid) begin
            mvn++;
            if (first_mv < 0)
               first_mv = i;
         end
      end
      chk("t2_rinc_count", rn, 2);
      chk("t2_valid_cycles", mvn, 1);
      chk("t2_latency", first_mv - last_r, 2);

      // Backpressure: credit must stop pops at four nibbles
      step();
      m_ready = 1'b0;
      for (int n = 1; n <= 6; n++)
         load(4'(n));
      expect_byte(8'h21, 1'b1);
      expect_byte(8'h43, 1'b0);
      expect_byte(8'h65, 1'b1);
      rn = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rinc)
            rn++;
      end
      chk("t3_rinc_count", rn, 4);
      chk("t3_head", {24'd0, m_data}, 32'h21);
      chk("t3_valid", {31'd0, m_valid}, 32'd1);
      step();
      m_ready = 1'b1;
      repeat (14) @(negedge clk);
      chk("t3_all_out", exp_q.size(), 0);
      chk("t3_fifo_empty", fifo_q.size(), 0);
      chk("t3_partial", {31'd0, partial}, 32'd0);

      // Flush discards a held odd nibble
      step();
      load(4'h1);
      load(4'h2);
      load(4'h7);
      expect_byte(8'h21, 1'b1);
      repeat (10) @(negedge clk);
      chk("t4_partial_held", {31'd0, partial}, 32'd1);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("t4_partial_flushed", {31'd0, partial}, 32'd0);
      step();
      load(4'h5);
      load(4'h6);
      expect_byte(8'h65, 1'b1);
      repeat (10) @(negedge clk);
      chk("t4_all_out", exp_q.size(), 0);
      chk("t4_partial", {31'd0, partial}, 32'd0);

      // Asynchronous reset with a buffered byte and a held nibble
      step();
      m_ready = 1'b0;
      load(4'h1);
      load(4'h2);
      load(4'h3);
      repeat (8) @(negedge clk);
      chk("t5_pre_partial", {31'd0, partial}, 32'd1);
      chk("t5_pre_valid", {31'd0, m_valid}, 32'd1);
      step();
      reset   = 1'b1;
      m_ready = 1'b1;
      #1;
      chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
      chk("t5_rst_data", {24'd0, m_data}, 32'd0);
      chk("t5_rst_partial", {31'd0, partial}, 32'd0);
      chk("t5_rst_rinc", {31'd0, rinc}, 32'd0);
      step();
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("t5_post_valid", {31'd0, m_valid}, 32'd0);
      end

      // Parity patterns: A3 has even weight, 07 odd weight
      step();
      load(4'h3);
      load(4'hA);
      load(4'h7);
      load(4'h0);
      expect_byte(8'hA3, 1'b1);
      expect_byte(8'h07, 1'b0);
      repeat (12) @(negedge clk);
      chk("t6_all_out", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
